// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage: FSM encoding,
// halt opcode and the IF/ID payload carried by the register and skid buffer.
package if_pkg;

    localparam int AW_DEF = 16;
    localparam int IW_DEF = 16;
    localparam logic [3:0] HALT_OP_DEF = 4'hf;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_FULL = 3'd3,
        S_HALT = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [IW_DEF-1:0] instr;
        logic [AW_DEF-1:0] pc;
    } if_payload_t;

endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// Single-entry holder for a response that arrives while the IF/ID register
// is stalled. Clear wins over load; load and drain never coincide in use.
module if_skid_buf
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  if_payload_t load_data,
    input  logic        drain,
    output logic        valid,
    output if_payload_t data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding memory request at a time, IF/ID register
// plus one skid entry, flush squashing (including in-flight responses) and HLT stop.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int IW = IW_DEF,
    parameter logic [3:0] HALT_OP = HALT_OP_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_addr,
    output logic          pc_hold,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [IW-1:0] mem_rdata,
    input  logic          flush,
    input  logic          id_stall,
    output logic          if_valid,
    output logic [IW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    output logic [AW-1:0] if_pc_plus2,
    output logic          halted
);

    localparam logic [AW-1:0] PC_STEP = AW'(2);

    fetch_state_t state, state_nxt;
    logic         drop_pending, drop_nxt;
    logic [AW-1:0] req_pc;

    logic          if_valid_q;
    if_payload_t   if_q;
    logic [AW-1:0] pc_plus2_q;

    logic          skid_valid;
    if_payload_t   skid_data;
    if_payload_t   resp_data;
    if_payload_t   if_src;

    logic resp_fire, resp_halt, skid_load, skid_drain;

    // A response is only accepted in S_WAIT, and never when it belongs to a squashed fetch.
    assign resp_fire  = (state == S_WAIT) && mem_rvalid && !drop_pending && !flush;
    assign resp_halt  = (mem_rdata[IW-1 -: 4] == HALT_OP);
    assign skid_load  = resp_fire && if_valid_q && id_stall;
    assign skid_drain = skid_valid && !id_stall;

    assign resp_data.instr = mem_rdata;
    assign resp_data.pc    = req_pc;
    assign if_src          = skid_drain ? skid_data : resp_data;

    assign mem_req  = (state == S_REQ);
    assign mem_addr = mem_req ? pc_addr : '0;
    assign pc_hold  = !(mem_req && mem_gnt);
    assign halted   = (state == S_HALT);

    assign if_valid    = if_valid_q;
    assign if_instr    = if_q.instr;
    assign if_pc       = if_q.pc;
    assign if_pc_plus2 = pc_plus2_q;

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_pending;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ:  if (mem_gnt) state_nxt = S_WAIT;
            S_WAIT: begin
                if (mem_rvalid) begin
                    drop_nxt = 1'b0;
                    if (drop_pending)   state_nxt = S_REQ;
                    else if (resp_halt) state_nxt = S_HALT;
                    else if (skid_load) state_nxt = S_FULL;
                    else                state_nxt = S_REQ;
                end
            end
            S_FULL: if (skid_drain) state_nxt = S_REQ;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
        // Any request already granted must still return; remember to drop its data.
        if (flush) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
            if ((state == S_WAIT && !mem_rvalid) || (state == S_REQ && mem_gnt)) begin
                state_nxt = S_WAIT;
                drop_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            drop_pending <= 1'b0;
            req_pc       <= '0;
        end else begin
            state        <= state_nxt;
            drop_pending <= drop_nxt;
            if (mem_req && mem_gnt) req_pc <= pc_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_q <= 1'b0;
            if_q       <= '0;
            pc_plus2_q <= '0;
        end else if (flush) begin
            if_valid_q <= 1'b0;
        end else if (!id_stall || !if_valid_q) begin
            if (skid_drain || resp_fire) begin
                if_valid_q <= 1'b1;
                if_q       <= if_src;
                pc_plus2_q <= if_src.pc + PC_STEP;
            end else begin
                if_valid_q <= 1'b0;
            end
        end
    end

    if_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .load      (skid_load),
        .load_data (resp_data),
        .drain     (skid_drain),
        .valid     (skid_valid),
        .data      (skid_data)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: transaction-level model (expected delivery queue,
// one outstanding fetch record, halt flag) driven by directed and random phases.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_addr;
  logic        pc_hold;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        flush;
  logic        id_stall;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        halted;

  // clock / reset
  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .pc_hold     (pc_hold),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .flush       (flush),
    .id_stall    (id_stall),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus2 (if_pc_plus2),
    .halted      (halted)
  );

  // scoreboard: {instr, pc} in delivery order (IF/ID register at the head, skid behind)
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // reference state
  logic [15:0] pc;
  bit          out_v, out_sq;
  logic [15:0] out_addr, out_instr;
  int          out_cnt;
  bit          halt_m, idle_m;

  // stimulus knobs
  int          gnt_pct, stall_pct, flush_pct, lat_min, lat_max;
  bit          allow_halt, force_flush, force_instr_v, fixed_tgt_v;
  int          force_stall_n, stale_cnt;
  logic [15:0] force_instr, fixed_tgt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_fetch(input bit squashed);
    logic [15:0] r;
    r = 16'($urandom);
    if (!allow_halt && r[15:12] == 4'hf) r[15:12] = 4'h0;
    if (force_instr_v) r = force_instr;
    force_instr_v = 1'b0;
    out_v     = 1'b1;
    out_sq    = squashed;
    out_addr  = pc;
    out_instr = r;
    out_cnt   = $urandom_range(lat_max, lat_min) - 1;
  endtask

  task automatic do_reset(input bit stale);
    rst = 1'b1;
    mem_gnt = 1'b0; id_stall = 1'b0; flush = 1'b0;
    mem_rvalid = stale; mem_rdata = 16'h1234;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_pc_hold", pc_hold, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_pc_plus2", if_pc_plus2, 0);
    check("rst_halted", halted, 0);
    rst = 1'b0;
    exp_q.delete();
    out_v = 1'b0; halt_m = 1'b0; idle_m = 1'b1;
    stale_cnt = stale ? 2 : 0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check combinational
  // outputs, advance the reference, then wait for the next falling edge.
  task automatic step();
    logic        exp_req, g, st, fl, rv;
    logic [15:0] rd, tgt;
    logic [31:0] head;
    check("if_valid", if_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("if_instr", if_instr, head[31:16]);
      check("if_pc", if_pc, head[15:0]);
      check("if_pc_plus2", if_pc_plus2, 16'(head[15:0] + 16'd2));
    end
    check("halted", halted, halt_m);
    exp_req = !idle_m && !out_v && !halt_m && (exp_q.size() < 2);

    g  = ($urandom_range(99, 0) < gnt_pct);
    st = (force_stall_n > 0) || ($urandom_range(99, 0) < stall_pct);
    fl = force_flush || ($urandom_range(99, 0) < flush_pct);
    rd = 16'($urandom);
    rv = 1'b0;
    if (stale_cnt > 0) begin
      rv = 1'b1;
      stale_cnt--;
    end else if (out_v && out_cnt == 0) begin
      rv = 1'b1;
      rd = out_instr;
    end
    mem_gnt = g; id_stall = st; flush = fl; mem_rvalid = rv; mem_rdata = rd; pc_addr = pc;
    #1;
    check("mem_req", mem_req, exp_req);
    if (exp_req) check("mem_addr", mem_addr, pc);
    check("pc_hold", pc_hold, !(exp_req && g));

    if (out_v && !rv && out_cnt > 0) out_cnt--;
    if (fl) begin
      exp_q.delete();
      halt_m = 1'b0;
      if (out_v && rv) out_v = 1'b0;
      else if (out_v) out_sq = 1'b1;
      if (exp_req && g) new_fetch(1'b1);
      tgt = fixed_tgt_v ? fixed_tgt : 16'($urandom_range(32767, 0) * 2);
      pc = tgt;
    end else begin
      if (exp_q.size() != 0 && !st) void'(exp_q.pop_front());
      if (out_v && rv) begin
        if (!out_sq) begin
          exp_q.push_back({rd, out_addr});
          if (rd[15:12] == 4'hf) halt_m = 1'b1;
        end
        out_v = 1'b0;
      end
      if (exp_req && g) begin
        new_fetch(1'b0);
        pc = pc + 16'd2;
      end
    end
    idle_m = 1'b0;
    force_flush = 1'b0;
    if (force_stall_n > 0) force_stall_n--;
    @(negedge clk);
  endtask

  task automatic set_knobs(input int gp, input int sp, input int fp, input int lmin, input int lmax, input bit ah);
    gnt_pct = gp; stall_pct = sp; flush_pct = fp; lat_min = lmin; lat_max = lmax; allow_halt = ah;
  endtask

  task automatic wait_outstanding(input string tag);
    for (int i = 0; i < 40 && !out_v; i++) step();
    check(tag, out_v, 1);
  endtask

  initial begin
    rst = 1'b1; pc_addr = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    flush = 1'b0; id_stall = 1'b0;
    force_flush = 1'b0; force_instr_v = 1'b0; fixed_tgt_v = 1'b0; fixed_tgt = '0;
    force_stall_n = 0; stale_cnt = 0; force_instr = '0;
    out_v = 1'b0; out_sq = 1'b0; out_addr = '0; out_instr = '0; out_cnt = 0;

    // basic stream: 1-cycle grant, 1-cycle response, pc 0,2,4,...
    set_knobs(100, 0, 0, 1, 1, 0);
    pc = 16'h0000;
    do_reset(1'b0);
    repeat (12) step();

    // ID stall held 4 cycles while an instruction is valid
    for (int i = 0; i < 10 && exp_q.size() == 0; i++) step();
    force_stall_n = 4;
    repeat (14) step();

    // flush while waiting on a slow response; new target 0x0040
    set_knobs(100, 0, 0, 4, 4, 0);
    wait_outstanding("wait_flush_req");
    force_flush = 1'b1; fixed_tgt_v = 1'b1; fixed_tgt = 16'h0040;
    repeat (12) step();

    // HLT fetched at 0x0010, stays halted, flush restarts
    set_knobs(100, 0, 0, 1, 1, 0);
    pc = 16'h0010;
    do_reset(1'b0);
    force_instr_v = 1'b1; force_instr = 16'hf000;
    repeat (14) step();
    check("halt_reached", halt_m, 1);
    force_flush = 1'b1; fixed_tgt = 16'h0080;
    repeat (8) step();

    // reset in the middle of a fetch, stale response afterwards
    set_knobs(100, 0, 0, 3, 3, 0);
    wait_outstanding("wait_rst_req");
    do_reset(1'b1);
    repeat (8) step();

    // address wrap: 0xfffe yields pc_plus2 0x0000
    set_knobs(100, 0, 0, 1, 1, 0);
    pc = 16'hfffc;
    do_reset(1'b0);
    repeat (10) step();

    // random traffic
    fixed_tgt_v = 1'b0;
    set_knobs(60, 30, 4, 1, 4, 1);
    repeat (3000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage sitting directly downstream of the program counter. Takes the current fetch address from the PC and issues one request at a time to instruction memory, which has variable latency. Delivers the returned instruction plus its address into the IF/ID boundary register. Back-pressures the PC with a hold signal, absorbs ID-stage stalls with a one-entry skid buffer, squashes wrong-path fetches on flush, and stops fetching after a HLT opcode.

## Interface
Parameters:
- AW, 16, address width
- IW, 16, instruction width
- HALT_OP, 4'hf, opcode (instr[15:12]) that stops fetching

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_addr  in  AW  current fetch address from the PC
- pc_hold  out  1  1 = PC must not advance this cycle
- mem_req  out  1  fetch request valid
- mem_addr  out  AW  fetch address; equals pc_addr while mem_req=1
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response valid; at least 1 cycle after grant
- mem_rdata  in  IW  returned instruction
- flush  in  1  squash all fetched/in-flight instructions (taken branch)
- id_stall  in  1  ID stage cannot accept the IF/ID register this cycle
- if_valid  out  1  IF/ID register holds a valid instruction
- if_instr  out  IW  instruction
- if_pc  out  AW  address of if_instr
- if_pc_plus2  out  AW  if_pc + 2, modulo 2^AW
- halted  out  1  HLT fetched; no further requests until flush

## Operation
- FSM states: S_IDLE, S_REQ, S_WAIT, S_FULL, S_HALT.
- S_IDLE: entered on reset. Lasts one cycle, then moves to S_REQ.
- S_REQ: mem_req=1, mem_addr=pc_addr.
  - On mem_gnt: latch pc_addr into req_pc, deassert pc_hold for that cycle only, go to S_WAIT.
- S_WAIT: mem_req=0. On mem_rvalid, the response with req_pc is placed as follows:
  - Into the IF/ID register if it is empty or being consumed (!id_stall).
  - Otherwise into the skid buffer.
- After placing the response:
  - If instr[15:12]==HALT_OP, go to S_HALT.
  - Else if the skid buffer is occupied, go to S_FULL.
  - Else go to S_REQ.
- S_FULL: no requests. When the skid buffer drains into the IF/ID register, go to S_REQ.
- S_HALT: no requests; halted=1. The HLT instruction itself is delivered downstream. Only flush leaves this state.
- pc_hold=1 in every cycle except a cycle with mem_req && mem_gnt. The PC therefore advances exactly once per issued fetch.
- IF/ID register advance:
  - When !id_stall, it loads the skid entry if one exists, otherwise the new response, otherwise it becomes invalid.
  - When id_stall, it holds its value.
- Flush has top priority over every other event in the same cycle:
  - Clears if_valid, the skid buffer and halted.
  - If in S_WAIT with no rvalid that cycle: set drop_pending, stay in S_WAIT, and discard the next rvalid. Then go to S_REQ.
  - If rvalid arrives in the same cycle as flush: discard it and go to S_REQ.
  - Otherwise go to S_REQ.
- A request being granted in the flush cycle is allowed to complete, and its response is discarded. drop_pending covers this case.
- if_pc_plus2 wraps modulo 2^AW; 16'hfffe yields 16'h0000.

## Timing
- Reset values: pc_hold=1, mem_req=0, mem_addr=0, if_valid=0, if_instr=0, if_pc=0, if_pc_plus2=0, halted=0, skid empty, drop_pending=0.
- First mem_req is asserted in the 2nd cycle after rst deasserts (the S_IDLE cycle comes first).
- Best-case throughput: 1-cycle grant and 1-cycle response give one instruction per 2 cycles.
- Fetch latency: if_valid rises on the edge that samples mem_rvalid.
- At most one outstanding request. At most two instructions buffered (IF/ID register plus skid).
- rst asserted mid-transaction: all state returns to reset values. A late mem_rvalid after reset is ignored because S_IDLE/S_REQ do not sample rvalid.

## Structure
- Shared package if_pkg holds:
  - FSM state enum (3-bit)
  - HALT_OP constant
  - AW/IW defaults
  - IF/ID payload struct (instr, pc)
- One sub-module, if_skid_buf: single-entry valid/data holder with load/drain/clear.

## Test plan
- Reset, then memory with 1-cycle grant and 1-cycle response; pc_addr steps 0,2,4 → mem_req in cycle 2; if_instr/if_pc pairs (I0,0),(I1,2),(I2,4) on alternate cycles; if_pc_plus2=2,4,6.
- id_stall held 4 cycles while an instruction is valid → next response goes to the skid buffer, state is S_FULL, mem_req=0, pc_hold=1; on release, instructions emerge in order with no loss or duplication.
- Flush in S_WAIT with rvalid 3 cycles later → that response is discarded, if_valid=0, next mem_addr is the new pc_addr (e.g. 16'h0040).
- Fetch 16'hf000 at address 16'h0010 → delivered with if_pc=16'h0010; halted=1; no mem_req for 10 cycles; flush then restarts fetching.
- rst asserted while in S_WAIT, with a stale rvalid the next cycle → all outputs at reset values and the stale data is never delivered.
- pc_addr=16'hfffe fetched → if_pc_plus2=16'h0000.
